yuv_rgb_stream_upsampler: RTL and testbench

Streaming 4:2:2 YUV to RGB converter, a parametrised successor to the fixed SRAM-sequenced colourspace datapath.
- Accepts one beat per pixel pair {Y_even, Y_odd, U, V} on a valid/ready port.
- Interpolates odd chroma with the 6-tap FIR (21, -52, 159, 159, -52, 21)/256, replicating samples at row edges.
- Converts both pixels to clipped RGB and emits one pair per output handshake.
- Sits between the SRAM read sequencer and the RGB write-back/VGA path.

---
 rtl/yuv_rgb_pkg.sv | 35 +++
 rtl/yuv_rgb_stream_upsampler_sat_clip.sv | 22 ++
 rtl/yuv_rgb_stream_upsampler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_yuv_rgb_stream_upsampler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv_rgb_pkg.sv
// Shared types and constants for the 4:2:2 YUV -> RGB stream upsampler.
// Holds the FSM state enum, the chroma FIR coefficients and rounding term,
// the RGB matrix coefficients (16.16 fixed point) and the Y/chroma offsets.
package yuv_rgb_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FILL,
    S_CALC0,
    S_CALC1,
    S_CALC2,
    S_CALC3,
    S_CALC4,
    S_CALC5,
    S_OUT,
    S_SHIFT
  } state_t;

  // Chroma interpolation: (21, -52, 159, 159, -52, 21) / 256
  localparam logic signed [31:0] FIR_C0  = 32'sd21;
  localparam logic signed [31:0] FIR_C1  = 32'sd52;
  localparam logic signed [31:0] FIR_C2  = 32'sd159;
  localparam logic signed [31:0] FIR_RND = 32'sd128;

  // Colour matrix, scaled by 2^16
  localparam logic signed [31:0] K_Y  = 32'sd76284;
  localparam logic signed [31:0] K_RV = 32'sd104595;
  localparam logic signed [31:0] K_GU = -32'sd25624;
  localparam logic signed [31:0] K_GV = -32'sd53281;
  localparam logic signed [31:0] K_BU = 32'sd132251;

  localparam logic signed [31:0] Y_OFS = 32'sd16;
  localparam logic signed [31:0] C_OFS = 32'sd128;

endpackage

// File: rtl/yuv_rgb_stream_upsampler_sat_clip.sv
// Saturating clip: signed 32-bit value to unsigned OUT_W bits.
// Ports: din (signed 32-bit), dout (OUT_W bits, clamped to [0, 2^OUT_W-1]).
module sat_clip #(
  parameter int OUT_W = 8
) (
  input  logic signed [31:0] din,
  output logic [OUT_W-1:0]   dout
);

  localparam logic signed [31:0] MAX_V = (32'sd1 <<< OUT_W) - 32'sd1;

  always_comb begin
    if (din < 32'sd0) begin
      dout = '0;
    end else if (din > MAX_V) begin
      dout = '1;
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/yuv_rgb_stream_upsampler.sv
// Streaming 4:2:2 YUV -> RGB converter with 6-tap chroma interpolation.
// One input beat carries a pixel pair {Y_even, Y_odd, U, V}; one output
// handshake delivers the RGB of both pixels plus frame/row markers.
//
// Ports:
//   CLOCK_50_I, resetn (async, active-low), clear (sync abort to frame start)
//   chroma_mode : 0 = FIR-interpolated odd chroma, 1 = replicate even chroma
//   in_valid/in_ready, in_y0/in_y1/in_u/in_v : input pair stream
//   out_valid/out_ready, out_{r,g,b}{0,1}, out_sof, out_eol : output stream
//   dbg_state : current FSM state
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. out_valid, the output data and the markers hold steady
// while out_valid=1 and out_ready=0. in_ready is low during clear.
module yuv_rgb_stream_upsampler
  import yuv_rgb_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 8,
  parameter int ROW_PAIRS = 160,
  parameter int ROWS      = 240
) (
  input  logic             CLOCK_50_I,
  input  logic             resetn,
  input  logic             clear,
  input  logic             chroma_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_y0,
  input  logic [IN_W-1:0]  in_y1,
  input  logic [IN_W-1:0]  in_u,
  input  logic [IN_W-1:0]  in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_r0,
  output logic [OUT_W-1:0] out_g0,
  output logic [OUT_W-1:0] out_b0,
  output logic [OUT_W-1:0] out_r1,
  output logic [OUT_W-1:0] out_g1,
  output logic [OUT_W-1:0] out_b1,
  output logic             out_sof,
  output logic             out_eol,
  output state_t           dbg_state
);

  localparam int IC_W = $clog2(ROW_PAIRS + 1);
  localparam int OC_W = $clog2(ROW_PAIRS);
  localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef struct packed {
    logic [IN_W-1:0] y0;
    logic [IN_W-1:0] y1;
    logic [IN_W-1:0] u;
    logic [IN_W-1:0] v;
  } beat_t;

  function automatic logic signed [31:0] ext(input logic [IN_W-1:0] x);
    return $signed({{(32-IN_W){1'b0}}, x});
  endfunction

  state_t            state_q, state_d;
  logic [IC_W-1:0]   in_cnt_q, in_cnt_d;
  logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
  logic [RC_W-1:0]   row_cnt_q, row_cnt_d;
  logic              mode_q, mode_d;
  beat_t             w_q [6];
  beat_t             w_d [6];
  logic signed [31:0] u_fir_q, u_fir_d, v_fir_q, v_fir_d, y_acc_q, y_acc_d;
  logic signed [31:0] r0_q, r0_d, g0_q, g0_d, b0_q, b0_d;
  logic signed [31:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;

  beat_t              in_beat;
  logic [IN_W-1:0]    u_odd, v_odd;
  logic signed [31:0] mul_a [3];
  logic signed [31:0] mul_b [3];
  logic signed [31:0] prod  [3];
  logic signed [31:0] fir_val;

  assign in_beat = {in_y0, in_y1, in_u, in_v};

  // Odd-pixel chroma: FIR result (or replicated even chroma) clipped to IN_W.
  sat_clip #(.OUT_W(IN_W)) u_clip_u (.din(u_fir_q), .dout(u_odd));
  sat_clip #(.OUT_W(IN_W)) u_clip_v (.din(v_fir_q), .dout(v_odd));

  sat_clip #(.OUT_W(OUT_W)) u_clip_r0 (.din(r0_q), .dout(out_r0));
  sat_clip #(.OUT_W(OUT_W)) u_clip_g0 (.din(g0_q), .dout(out_g0));
  sat_clip #(.OUT_W(OUT_W)) u_clip_b0 (.din(b0_q), .dout(out_b0));
  sat_clip #(.OUT_W(OUT_W)) u_clip_r1 (.din(r1_q), .dout(out_r1));
  sat_clip #(.OUT_W(OUT_W)) u_clip_g1 (.din(g1_q), .dout(out_g1));
  sat_clip #(.OUT_W(OUT_W)) u_clip_b1 (.din(b1_q), .dout(out_b1));

  // Operand selection for the three shared multipliers. CALC2/3 work on
  // the even pixel (w[2] chroma), CALC4/5 on the odd pixel (interpolated).
  always_comb begin
    logic              sel_odd;
    logic signed [31:0] yp, up, vp;
    sel_odd = (state_q == S_CALC4) || (state_q == S_CALC5);
    yp = (sel_odd ? ext(w_q[2].y1) : ext(w_q[2].y0)) - Y_OFS;
    up = (sel_odd ? ext(u_odd) : ext(w_q[2].u)) - C_OFS;
    vp = (sel_odd ? ext(v_odd) : ext(w_q[2].v)) - C_OFS;
    for (int i = 0; i < 3; i++) begin
      mul_a[i] = '0;
      mul_b[i] = '0;
    end
    case (state_q)
      S_CALC0: begin
        mul_a[0] = FIR_C0; mul_b[0] = ext(w_q[0].u) + ext(w_q[5].u);
        mul_a[1] = FIR_C1; mul_b[1] = ext(w_q[1].u) + ext(w_q[4].u);
        mul_a[2] = FIR_C2; mul_b[2] = ext(w_q[2].u) + ext(w_q[3].u);
      end
      S_CALC1: begin
        mul_a[0] = FIR_C0; mul_b[0] = ext(w_q[0].v) + ext(w_q[5].v);
        mul_a[1] = FIR_C1; mul_b[1] = ext(w_q[1].v) + ext(w_q[4].v);
        mul_a[2] = FIR_C2; mul_b[2] = ext(w_q[2].v) + ext(w_q[3].v);
      end
      S_CALC2, S_CALC4: begin
        mul_a[0] = K_Y;  mul_b[0] = yp;
        mul_a[1] = K_RV; mul_b[1] = vp;
        mul_a[2] = K_BU; mul_b[2] = up;
      end
      S_CALC3, S_CALC5: begin
        mul_a[0] = K_GU; mul_b[0] = up;
        mul_a[1] = K_GV; mul_b[1] = vp;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 3; i++) prod[i] = mul_a[i] * mul_b[i];
  end

  assign fir_val = (prod[0] - prod[1] + prod[2] + FIR_RND) >>> 8;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    row_cnt_d = row_cnt_q;
    mode_d    = mode_q;
    u_fir_d   = u_fir_q;
    v_fir_d   = v_fir_q;
    y_acc_d   = y_acc_q;
    r0_d = r0_q; g0_d = g0_q; b0_d = b0_q;
    r1_d = r1_q; g1_d = g1_q; b1_d = b1_q;
    for (int i = 0; i < 6; i++) w_d[i] = w_q[i];
    in_ready = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // First beat of a row is replicated into k-2, k-1 and k.
          if (in_cnt_q == IC_W'(0)) begin
            w_d[0] = in_beat;
            w_d[1] = in_beat;
            w_d[2] = in_beat;
          end else if (in_cnt_q == IC_W'(1)) begin
            w_d[3] = in_beat;
          end else if (in_cnt_q == IC_W'(2)) begin
            w_d[4] = in_beat;
          end else begin
            w_d[5]  = in_beat;
            mode_d  = chroma_mode;
            state_d = S_CALC0;
          end
          in_cnt_d = in_cnt_q + IC_W'(1);
        end
      end
      S_CALC0: begin
        u_fir_d = mode_q ? ext(w_q[2].u) : fir_val;
        state_d = S_CALC1;
      end
      S_CALC1: begin
        v_fir_d = mode_q ? ext(w_q[2].v) : fir_val;
        state_d = S_CALC2;
      end
      S_CALC2: begin
        y_acc_d = prod[0];
        r0_d    = (prod[0] + prod[1]) >>> 16;
        b0_d    = (prod[0] + prod[2]) >>> 16;
        state_d = S_CALC3;
      end
      S_CALC3: begin
        g0_d    = (y_acc_q + prod[0] + prod[1]) >>> 16;
        state_d = S_CALC4;
      end
      S_CALC4: begin
        y_acc_d = prod[0];
        r1_d    = (prod[0] + prod[1]) >>> 16;
        b1_d    = (prod[0] + prod[2]) >>> 16;
        state_d = S_CALC5;
      end
      S_CALC5: begin
        g1_d    = (y_acc_q + prod[0] + prod[1]) >>> 16;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          if (out_eol) begin
            out_cnt_d = '0;
            in_cnt_d  = '0;
            row_cnt_d = (row_cnt_q == RC_W'(ROWS - 1)) ? '0 : row_cnt_q + RC_W'(1);
            state_d   = S_FILL;
          end else begin
            out_cnt_d = out_cnt_q + OC_W'(1);
            state_d   = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (in_cnt_q < IC_W'(ROW_PAIRS)) begin
          in_ready = 1'b1;
          if (in_valid) begin
            for (int i = 0; i < 5; i++) w_d[i] = w_q[i+1];
            w_d[5]   = in_beat;
            in_cnt_d = in_cnt_q + IC_W'(1);
            state_d  = S_CALC0;
          end
        end else begin
          // Right edge: the last pair stays in w[5] as it slides down.
          for (int i = 0; i < 5; i++) w_d[i] = w_q[i+1];
          state_d = S_CALC0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // clear wins over both handshakes: nothing is taken in or handed out.
    if (clear) begin
      state_d   = S_FILL;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      row_cnt_d = '0;
      in_ready  = 1'b0;
      for (int i = 0; i < 6; i++) w_d[i] = w_q[i];
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      row_cnt_q <= '0;
      mode_q    <= 1'b0;
      u_fir_q   <= '0;
      v_fir_q   <= '0;
      y_acc_q   <= '0;
      r0_q <= '0; g0_q <= '0; b0_q <= '0;
      r1_q <= '0; g1_q <= '0; b1_q <= '0;
      for (int i = 0; i < 6; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      row_cnt_q <= row_cnt_d;
      mode_q    <= mode_d;
      u_fir_q   <= u_fir_d;
      v_fir_q   <= v_fir_d;
      y_acc_q   <= y_acc_d;
      r0_q <= r0_d; g0_q <= g0_d; b0_q <= b0_d;
      r1_q <= r1_d; g1_q <= g1_d; b1_q <= b1_d;
      for (int i = 0; i < 6; i++) w_q[i] <= w_d[i];
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_sof   = out_valid && (row_cnt_q == '0) && (out_cnt_q == '0);
  assign out_eol   = out_valid && (out_cnt_q == OC_W'(ROW_PAIRS - 1));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_yuv_rgb_stream_upsampler.sv
// Bench for yuv_rgb_stream_upsampler: directed rows (flat black/white/red,
// chroma ramp in both chroma modes, backpressure, clear mid-row) with an
// expected-pair queue checked by an independent output monitor.
module tb_yuv_rgb_stream_upsampler;
  import yuv_rgb_pkg::*;

  localparam int RP = 160;

  // ---------------- clock / reset ----------------
  logic CLOCK_50_I = 1'b0;
  always #5 CLOCK_50_I = ~CLOCK_50_I;

  logic       resetn, clear, chroma_mode, in_valid, in_ready;
  logic [7:0] in_y0, in_y1, in_u, in_v;
  logic       out_valid, out_ready, out_sof, out_eol;
  logic [7:0] out_r0, out_g0, out_b0, out_r1, out_g1, out_b1;
  state_t     dbg_state;

  yuv_rgb_stream_upsampler dut (
    .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .clear(clear),
    .chroma_mode(chroma_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_y0(in_y0), .in_y1(in_y1), .in_u(in_u), .in_v(in_v),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r0(out_r0), .out_g0(out_g0), .out_b0(out_b0),
    .out_r1(out_r1), .out_g1(out_g1), .out_b1(out_b1),
    .out_sof(out_sof), .out_eol(out_eol), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  int          total_out = 0;
  int          bp_at = -1;
  int          row_idx = 0;
  logic [49:0] exp_q[$];   // {r0,g0,b0,r1,g1,b1,sof,eol}
  logic [7:0]  py0[RP], py1[RP], pu[RP], pv[RP];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clipi(input int x, input int mx);
    return (x < 0) ? 0 : ((x > mx) ? mx : x);
  endfunction

  function automatic int fir6(input int a, input int b, input int c,
                              input int d, input int e, input int f);
    return clipi((21*(a+f) - 52*(b+e) + 159*(c+d) + 128) >>> 8, 255);
  endfunction

  function automatic logic [23:0] rgb_px(input int y, input int u, input int v);
    int yp, r, g, b;
    yp = 76284 * (y - 16);
    r  = (yp + 104595 * (v - 128)) >>> 16;
    g  = (yp - 25624 * (u - 128) - 53281 * (v - 128)) >>> 16;
    b  = (yp + 132251 * (u - 128)) >>> 16;
    return {8'(clipi(r, 255)), 8'(clipi(g, 255)), 8'(clipi(b, 255))};
  endfunction

  function automatic logic [47:0] model_pair(input int k, input bit mode);
    int idx[6];
    int uo, vo;
    for (int i = 0; i < 6; i++) begin
      idx[i] = k - 2 + i;
      if (idx[i] < 0) idx[i] = 0;
      if (idx[i] > RP - 1) idx[i] = RP - 1;
    end
    if (mode) begin
      uo = pu[k];
      vo = pv[k];
    end else begin
      uo = fir6(pu[idx[0]], pu[idx[1]], pu[idx[2]], pu[idx[3]], pu[idx[4]], pu[idx[5]]);
      vo = fir6(pv[idx[0]], pv[idx[1]], pv[idx[2]], pv[idx[3]], pv[idx[4]], pv[idx[5]]);
    end
    return {rgb_px(py0[k], pu[k], pv[k]), rgb_px(py1[k], uo, vo)};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic fill_flat(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    for (int k = 0; k < RP; k++) begin
      py0[k] = y; py1[k] = y; pu[k] = u; pv[k] = v;
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < RP; k++) begin
      py0[k] = 8'((k * 3) % 256);
      py1[k] = 8'd235;
      pu[k]  = 8'((k * 10) % 256);
      pv[k]  = 8'd128;
    end
  endtask

  task automatic push_row(input bit mode, input bit hand, input logic [47:0] hv);
    logic [47:0] d;
    for (int k = 0; k < RP; k++) begin
      d = hand ? hv : model_pair(k, mode);
      exp_q.push_back({d, 1'(row_idx == 0 && k == 0), 1'(k == RP - 1)});
    end
  endtask

  task automatic drive_beat(input int k);
    int t;
    t = 0;
    @(negedge CLOCK_50_I);
    in_y0 = py0[k]; in_y1 = py1[k]; in_u = pu[k]; in_v = pv[k];
    in_valid = 1'b1;
    while (!in_ready && t < 3000) begin
      @(negedge CLOCK_50_I);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout: beat %0d not accepted, in_ready=%0b required 1", k, in_ready);
    end
    @(posedge CLOCK_50_I);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int target);
    int t;
    t = 0;
    while (total_out < target && t < 4000) begin
      @(negedge CLOCK_50_I);
      t++;
    end
    if (total_out < target) begin
      checks++; errors++;
      $display("FAIL out_timeout: outputs %0d required %0d", total_out, target);
    end
  endtask

  task automatic run_row(input bit mode, input bit hand, input logic [47:0] hv);
    int base;
    base = total_out;
    chroma_mode = mode;
    push_row(mode, hand, hv);
    for (int k = 0; k < RP; k++) drive_beat(k);
    wait_outputs(base + RP);
    row_idx++;
  endtask

  // ---------------- output ready / backpressure ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLOCK_50_I);
      #2;
      if (bp_at >= 0 && total_out == bp_at && out_valid) begin
        out_ready = 1'b0;
        repeat (10) @(posedge CLOCK_50_I);
        #2 out_ready = 1'b1;
        bp_at = -1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [49:0] got;
    forever begin
      @(negedge CLOCK_50_I);
      if (resetn && out_valid) begin
        got = {out_r0, out_g0, out_b0, out_r1, out_g1, out_b1, out_sof, out_eol};
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h with empty expected queue", got);
          if (out_ready) total_out++;
        end else if (out_ready) begin
          chk("pair", 64'(got), 64'(exp_q.pop_front()));
          total_out++;
        end else begin
          chk("stall_data", 64'(got), 64'(exp_q[0]));
          chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    resetn = 1'b0; clear = 1'b0; chroma_mode = 1'b0; in_valid = 1'b0;
    in_y0 = '0; in_y1 = '0; in_u = '0; in_v = '0;
    repeat (3) @(negedge CLOCK_50_I);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_sof_eol", 64'({out_sof, out_eol}), 64'd0);
    chk("reset_data", 64'({out_r0, out_g0, out_b0, out_r1, out_g1, out_b1}), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(S_IDLE));
    resetn = 1'b1;

    fill_flat(8'd16, 8'd128, 8'd128);
    run_row(1'b0, 1'b1, 48'h0);                       // black, sof on pair 0
    fill_flat(8'd235, 8'd128, 8'd128);
    run_row(1'b0, 1'b1, {6{8'd254}});                 // white
    fill_flat(8'd16, 8'd128, 8'd255);
    run_row(1'b0, 1'b1, {8'd202, 8'd0, 8'd0, 8'd202, 8'd0, 8'd0}); // red clip

    // Pair 0 of the ramp: FIR U_odd = 5 -> odd B = 6; replicated U_odd = 0 -> odd B = 0.
    fill_ramp();
    chk("ramp_model_b1_fir", 64'(model_pair(0, 1'b0) & 48'hff), 64'd6);
    chk("ramp_model_b1_rep", 64'(model_pair(0, 1'b1) & 48'hff), 64'd0);
    bp_at = total_out + 3;
    run_row(1'b0, 1'b0, 48'h0);
    run_row(1'b1, 1'b0, 48'h0);

    // clear at pair 50 with a beat offered in the same cycle
    fill_flat(8'd235, 8'd128, 8'd128);
    chroma_mode = 1'b0;
    push_row(1'b0, 1'b1, {6{8'd254}});
    base = total_out;
    for (int k = 0; k < 53; k++) drive_beat(k);
    wait_outputs(base + 50);
    @(negedge CLOCK_50_I);
    in_y0 = 8'd99; in_y1 = 8'd7; in_u = 8'd0; in_v = 8'd255;
    in_valid = 1'b1;
    clear = 1'b1;
    #1 chk("clear_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLOCK_50_I);
    #1 clear = 1'b0; in_valid = 1'b0;
    @(negedge CLOCK_50_I);
    chk("clear_out_valid", 64'(out_valid), 64'd0);
    chk("clear_state", 64'(dbg_state), 64'(S_FILL));
    chk("clear_fill_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    row_idx = 0;

    fill_flat(8'd16, 8'd128, 8'd255);
    run_row(1'b0, 1'b1, {8'd202, 8'd0, 8'd0, 8'd202, 8'd0, 8'd0}); // sof again

    repeat (20) @(negedge CLOCK_50_I);
    chk("total_out", 64'(total_out), 64'(5 * RP + 50 + RP));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
